// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback (A) wins over a queued long-latency
// requester (B); publishes a pending scoreboard and a starvation hold toward the pipeline.
// Ports: clk, reset (sync, high); a_valid/a_reg/a_data; b_valid/b_ready/b_reg/b_data;
// rf_we/rf_waddr/rf_wdata (registered); pending[31:0]; a_hold; err (sticky).
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int B_DEPTH    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pending,
  output logic              a_hold,
  output logic              err
);

  localparam int PTR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int CNT_W = $clog2(B_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(B_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(B_DEPTH);
  localparam logic [ST_W-1:0]  SMAX_C   = ST_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUEUED,
    S_HOLD
  } state_e;

  logic [4:0]        breg_q  [B_DEPTH];
  logic [DATA_W-1:0] bdata_q [B_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              out_b_q, out_b_d;
  logic              err_q, err_d;

  logic sel_a;
  logic pop;
  logic push;

  assign b_ready  = (cnt_q < DEPTH_C);
  assign a_hold   = (state_q == S_HOLD);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err      = err_q;

  // Head pops only on registered occupancy, so a fresh push is never bypassed.
  always_comb begin
    sel_a = a_valid && (a_reg != 5'd0);
    pop   = !sel_a && (cnt_q != '0);
    push  = b_valid && b_ready && (b_reg != 5'd0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    starve_d   = starve_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    rf_we_d = sel_a || pop;
    out_b_d = pop;
    unique case (1'b1)
      sel_a: begin
        rf_waddr_d = a_reg;
        rf_wdata_d = a_data;
      end
      pop: begin
        rf_waddr_d = breg_q[rd_ptr_q];
        rf_wdata_d = bdata_q[rd_ptr_q];
      end
      default: ;
    endcase

    if ((cnt_q == '0) || pop) begin
      starve_d = '0;
    end else if (sel_a && (starve_q != SMAX_C)) begin
      starve_d = starve_q + 1'b1;
    end

    if (cnt_d == '0) begin
      state_d = S_IDLE;
    end else if (starve_d == SMAX_C) begin
      state_d = S_HOLD;
    end else begin
      state_d = S_QUEUED;
    end

    err_d = err_q || (a_valid && a_hold);
  end

  // Scoreboard: live FIFO entries plus a B write sitting in the output stage.
  always_comb begin
    int idx;
    pending = '0;
    for (int k = 0; k < B_DEPTH; k++) begin
      idx = int'(rd_ptr_q) + k;
      if (idx >= B_DEPTH) begin
        idx = idx - B_DEPTH;
      end
      if (k < int'(cnt_q)) begin
        pending[breg_q[PTR_W'(idx)]] = 1'b1;
      end
    end
    if (rf_we_q && out_b_q) begin
      pending[rf_waddr_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      state_q    <= S_IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      out_b_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      out_b_q    <= out_b_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      breg_q[wr_ptr_q]  <= b_reg;
      bdata_q[wr_ptr_q] <= b_data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_write_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid;
  logic [4:0]    a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_reg;
  logic [DW-1:0] b_data;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pending;
  logic          a_hold;
  logic          err;

  rf_write_arbiter #(
    .DATA_W(DW), .B_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_reg(b_reg), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .a_hold(a_hold), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model
  typedef struct {
    logic [4:0]    r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_we    = 0;
  logic [4:0]    m_waddr = 0;
  logic [DW-1:0] m_wdata = 0;
  logic          m_outb  = 0;
  int            m_starve = 0;
  logic          m_err   = 0;
  logic          started = 0;

  always @(posedge clk) begin
    int  sz;
    logic win_a;
    logic take_b;
    started = 1'b1;
    if (reset) begin
      mq.delete();
      m_we = 0; m_waddr = 0; m_wdata = 0; m_outb = 0;
      m_starve = 0; m_err = 0;
    end else begin
      sz     = mq.size();
      win_a  = a_valid && (a_reg != 0);
      take_b = !win_a && (sz > 0);
      if (a_valid && (m_starve == SMAX)) m_err = 1;
      if (sz == 0 || take_b) m_starve = 0;
      else if (win_a && m_starve < SMAX) m_starve++;
      m_we   = win_a || take_b;
      m_outb = take_b;
      if (win_a) begin
        m_waddr = a_reg;
        m_wdata = a_data;
      end else if (take_b) begin
        m_waddr = mq[0].r;
        m_wdata = mq[0].d;
        void'(mq.pop_front());
      end
      if (b_valid && sz < DEPTH && b_reg != 0) mq.push_back('{b_reg, b_data});
    end
  end

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    if (m_we && m_outb) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("m_rf_we", rf_we, m_we);
      chk("m_rf_waddr", rf_waddr, m_waddr);
      chk("m_rf_wdata", rf_wdata, m_wdata);
      chk("m_pending", pending, m_pending());
      chk("m_b_ready", b_ready, mq.size() < DEPTH);
      chk("m_a_hold", a_hold, m_starve == SMAX);
      chk("m_err", err, m_err);
    end
  end

  // Apply current inputs across one rising edge; return 1 time unit after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    step(2);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", pending, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_hold", a_hold, 0);
    chk("rst_err", err, 0);
    reset = 0;
    step();

    // A only
    a_valid = 1; a_reg = 5; a_data = 32'h0000_1234;
    step();
    chk("a_we", rf_we, 1);
    chk("a_waddr", rf_waddr, 5);
    chk("a_wdata", rf_wdata, 32'h0000_1234);
    a_reg = 0; a_data = 32'hdead_beef;
    step();
    chk("a0_we", rf_we, 0);
    chk("a0_waddr_hold", rf_waddr, 5);
    idle_in();

    // B single
    b_valid = 1; b_reg = 7; b_data = 32'hABCD_0000;
    step();
    b_valid = 0;
    chk("b_pend_t1", pending[7], 1);
    chk("b_we_t1", rf_we, 0);
    step();
    chk("b_we_t2", rf_we, 1);
    chk("b_waddr_t2", rf_waddr, 7);
    chk("b_wdata_t2", rf_wdata, 32'hABCD_0000);
    chk("b_pend_t2", pending[7], 1);
    step();
    chk("b_pend_t3", pending[7], 0);
    chk("b_we_t3", rf_we, 0);
    b_valid = 1; b_reg = 0; b_data = 32'h5555_5555;
    step();
    b_valid = 0;
    step(2);
    chk("b0_pending", pending, 0);
    chk("b0_we", rf_we, 0);

    // Full and ordering
    a_valid = 1; a_reg = 1; a_data = 32'h11;
    b_valid = 1; b_reg = 3; b_data = 32'h33;
    step();
    b_reg = 4; b_data = 32'h44;
    step();
    b_valid = 0;
    chk("full_b_ready", b_ready, 0);
    chk("full_pending", pending, 32'h18);
    a_valid = 0;
    step();
    chk("ord_waddr0", rf_waddr, 3);
    chk("ord_wdata0", rf_wdata, 32'h33);
    chk("ord_b_ready", b_ready, 1);
    step();
    chk("ord_we1", rf_we, 1);
    chk("ord_waddr1", rf_waddr, 4);
    step();
    chk("ord_we2", rf_we, 0);

    // Starvation, released by dropping A
    a_valid = 1; a_reg = 2; a_data = 32'h22;
    b_valid = 1; b_reg = 9; b_data = 32'h99;
    step();
    b_valid = 0;
    step(3);
    chk("stv_hold_early", a_hold, 0);
    step();
    chk("stv_hold", a_hold, 1);
    a_valid = 0;
    step();
    chk("stv_pop_waddr", rf_waddr, 9);
    chk("stv_hold_drop", a_hold, 0);
    chk("stv_err0", err, 0);

    // Starvation with A kept high into the hold
    a_valid = 1;
    b_valid = 1; b_reg = 10; b_data = 32'hAA;
    step();
    b_valid = 0;
    step(4);
    chk("stv2_hold", a_hold, 1);
    step();
    chk("stv2_err", err, 1);
    chk("stv2_hold_stays", a_hold, 1);
    chk("stv2_a_wins", rf_waddr, 2);
    a_valid = 0;
    step();
    chk("stv2_pop", rf_waddr, 10);
    chk("stv2_hold_drop", a_hold, 0);
    step();
    chk("stv2_err_sticky", err, 1);

    // Reset with two entries queued
    a_valid = 1; a_reg = 1;
    b_valid = 1; b_reg = 11; b_data = 32'hB1;
    step();
    b_reg = 12; b_data = 32'hB2;
    step();
    b_valid = 0;
    chk("rq_pending", pending, 32'h1800);
    reset = 1;
    step();
    chk("rq_pending0", pending, 0);
    chk("rq_we0", rf_we, 0);
    chk("rq_err0", err, 0);
    reset = 0; a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rq_no_we", rf_we, 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
